// File: rtl/rf_dual.sv
// rf_dual: 2-write / 4-read register file for a dual-issue pipeline.
// Write-back data is bypassed to the read ports in the same cycle. A per-register
// counter of in-flight writers (issued but not yet written back) drives operand
// readiness. A sticky error flag records any counter overflow or underflow.
module rf_dual #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5,
    parameter int unsigned CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    // issue side: destinations of instructions entering execution
    input  logic          iss_we1,
    input  logic          iss_we2,
    input  logic [AW-1:0] iss_rd1,
    input  logic [AW-1:0] iss_rd2,
    // write-back side
    input  logic          wb_we1,
    input  logic          wb_we2,
    input  logic [AW-1:0] wb_addr1,
    input  logic [AW-1:0] wb_addr2,
    input  logic [DW-1:0] wb_data1,
    input  logic [DW-1:0] wb_data2,
    input  logic          wb_num1,
    input  logic          wb_num2,
    // read side
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    input  logic [AW-1:0] raddr3,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    output logic [DW-1:0] rdata3,
    output logic          rready0,
    output logic          rready1,
    output logic          rready2,
    output logic          rready3,
    output logic          sb_err
);

    localparam int unsigned NR = 1 << AW;
    localparam int unsigned NP = 4;
    localparam logic [CW-1:0] CMAX = '1;

    // State
    logic [DW-1:0] r_mem [NR];
    logic [CW-1:0] r_cnt [NR];
    logic          r_sb_err;

    // Write arbitration
    logic w_same_addr;
    logic w_p1_wins;
    logic w_wr1;
    logic w_wr2;

    // Scoreboard arithmetic; two extra bits hold the sign and the carry of cnt+2
    logic [1:0]           w_inc   [NR];
    logic [1:0]           w_dec   [NR];
    logic signed [CW+1:0] w_sum   [NR];
    logic [CW-1:0]        w_cnt_d [NR];
    logic                 w_err_any;

    // Read ports gathered into arrays
    logic [AW-1:0] w_raddr  [NP];
    logic [DW-1:0] w_rdata  [NP];
    logic          w_rready [NP];

    // A same-address dual write keeps only the younger instruction's data.
    // Port 1 wins only when it alone is flagged younger; every other case goes to port 2.
    assign w_same_addr = wb_we1 && wb_we2 && (wb_addr1 == wb_addr2) && (wb_addr1 != '0);
    assign w_p1_wins   = wb_num1 && !wb_num2;
    assign w_wr1       = wb_we1 && (wb_addr1 != '0) && !(w_same_addr && !w_p1_wins);
    assign w_wr2       = wb_we2 && (wb_addr2 != '0) && !(w_same_addr && w_p1_wins);

    assign w_raddr[0] = raddr0;
    assign w_raddr[1] = raddr1;
    assign w_raddr[2] = raddr2;
    assign w_raddr[3] = raddr3;

    // Per-register issue increments and write-back decrements (0..2 each)
    always_comb begin
        for (int unsigned r = 0; r < NR; r++) begin
            w_inc[r] = {1'b0, iss_we1 && (iss_rd1 == AW'(r))}
                     + {1'b0, iss_we2 && (iss_rd2 == AW'(r))};
            w_dec[r] = {1'b0, wb_we1 && (wb_addr1 == AW'(r))}
                     + {1'b0, wb_we2 && (wb_addr2 == AW'(r))};
        end
    end

    // Next counter values with saturation; register 0 is never tracked
    always_comb begin
        w_err_any = 1'b0;
        for (int unsigned r = 0; r < NR; r++) begin
            w_sum[r]   = $signed({2'b00, r_cnt[r]})
                       + $signed({{CW{1'b0}}, w_inc[r]})
                       - $signed({{CW{1'b0}}, w_dec[r]});
            w_cnt_d[r] = '0;
            if (r != 0) begin
                if (w_sum[r][CW+1]) begin
                    // underflow: more write-backs than recorded writers
                    w_cnt_d[r] = '0;
                    w_err_any  = 1'b1;
                end else if (w_sum[r] > $signed({2'b00, CMAX})) begin
                    w_cnt_d[r] = CMAX;
                    w_err_any  = 1'b1;
                end else begin
                    w_cnt_d[r] = w_sum[r][CW-1:0];
                end
            end
        end
    end

    // Read mux: register 0 is hardwired, write-back data bypasses storage
    always_comb begin
        for (int unsigned p = 0; p < NP; p++) begin
            w_rdata[p] = r_mem[w_raddr[p]];
            if (w_raddr[p] == '0) begin
                w_rdata[p] = '0;
            end else if (w_wr2 && (wb_addr2 == w_raddr[p])) begin
                w_rdata[p] = wb_data2;
            end else if (w_wr1 && (wb_addr1 == w_raddr[p])) begin
                w_rdata[p] = wb_data1;
            end
        end
    end

    // Readiness: no writer left once this cycle's write-backs retire (issues ignored)
    always_comb begin
        for (int unsigned p = 0; p < NP; p++) begin
            w_rready[p] = (w_raddr[p] == '0)
                       || ({2'b00, r_cnt[w_raddr[p]]} == {{CW{1'b0}}, w_dec[w_raddr[p]]});
        end
    end

    // Register storage; the two ports never target the same register after arbitration
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NR; r++) begin
                r_mem[r] <= '0;
            end
        end else begin
            if (w_wr1) begin
                r_mem[wb_addr1] <= wb_data1;
            end
            if (w_wr2) begin
                r_mem[wb_addr2] <= wb_data2;
            end
        end
    end

    // Scoreboard counters and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NR; r++) begin
                r_cnt[r] <= '0;
            end
            r_sb_err <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NR; r++) begin
                r_cnt[r] <= w_cnt_d[r];
            end
            if (w_err_any) begin
                r_sb_err <= 1'b1;
            end
        end
    end

    assign rdata0  = w_rdata[0];
    assign rdata1  = w_rdata[1];
    assign rdata2  = w_rdata[2];
    assign rdata3  = w_rdata[3];
    assign rready0 = w_rready[0];
    assign rready1 = w_rready[1];
    assign rready2 = w_rready[2];
    assign rready3 = w_rready[3];
    assign sb_err  = r_sb_err;

endmodule
